// File: rtl/t_ff_seq_pkg.sv
// Shared types and default widths for the T flip-flop sequencer.
package t_ff_seq_pkg;

    localparam int unsigned N_DEF  = 4;
    localparam int unsigned CW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/t_ff.sv
// Single T flip-flop: inverts q on every rising edge where t is high.
module t_ff (
    input  logic clk,
    input  logic n_rst,
    input  logic t,
    output logic q
);

    // Toggle storage with asynchronous clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/t_ff_seq_ctrl.sv
// Sequencer that issues count toggle pulses, spaced by interval idle cycles,
// onto a masked bank of T flip-flops, with abort and a completion pulse.
module t_ff_seq_ctrl
    import t_ff_seq_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [N-1:0]  cmd_mask,
    input  logic [CW-1:0] cmd_count,
    input  logic [CW-1:0] cmd_interval,
    input  logic          abort,
    output logic [N-1:0]  t_out,
    output logic [N-1:0]  q,
    output logic          busy,
    output logic          done
);

    state_t        state, state_nx;
    logic [N-1:0]  mask_r, mask_nx;
    logic [CW-1:0] interval_r, interval_nx;
    logic [CW-1:0] remaining, remaining_nx;
    logic [CW-1:0] gap_cnt, gap_nx;

    // State and command/counter registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            mask_r     <= '0;
            interval_r <= '0;
            remaining  <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nx;
            mask_r     <= mask_nx;
            interval_r <= interval_nx;
            remaining  <= remaining_nx;
            gap_cnt    <= gap_nx;
        end
    end

    // Next-state and counter update; counters saturate at zero
    always_comb begin
        state_nx     = state;
        mask_nx      = mask_r;
        interval_nx  = interval_r;
        remaining_nx = remaining;
        gap_nx       = gap_cnt;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    mask_nx      = cmd_mask;
                    interval_nx  = cmd_interval;
                    remaining_nx = cmd_count;
                    state_nx     = (cmd_count == '0) ? DONE : PULSE;
                end
            end
            PULSE: begin
                if (abort) begin
                    state_nx = DONE;
                end else begin
                    remaining_nx = (remaining != '0) ? remaining - CW'(1) : '0;
                    if (remaining <= CW'(1)) begin
                        state_nx = DONE;
                    end else if (interval_r == '0) begin
                        state_nx = PULSE;
                    end else begin
                        state_nx = GAP;
                        gap_nx   = interval_r;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_nx = DONE;
                end else begin
                    gap_nx = (gap_cnt != '0) ? gap_cnt - CW'(1) : '0;
                    if (gap_cnt <= CW'(1)) begin
                        state_nx = PULSE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Status decoded directly from the state register; abort gates the pulse
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign t_out     = ((state == PULSE) && !abort) ? mask_r : '0;

    // Flip-flop bank driven by the toggle enables
    for (genvar i = 0; i < int'(N); i++) begin : g_bank
        t_ff u_t_ff (
            .clk   (clk),
            .n_rst (n_rst),
            .t     (t_out[i]),
            .q     (q[i])
        );
    end

endmodule

// File: tb/tb_t_ff_seq_ctrl.sv
// Directed table-driven bench for t_ff_seq_ctrl.
module tb_t_ff_seq_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_mask;
    logic [7:0] cmd_count;
    logic [7:0] cmd_interval;
    logic       abort;
    logic [3:0] t_out;
    logic [3:0] q;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] count;
        logic [7:0] interval;
        int         abort_at;
        logic [3:0] q_end;
    } vec_t;

    vec_t vecs[9];

    t_ff_seq_ctrl #(.N(4), .CW(8)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mask     (cmd_mask),
        .cmd_count    (cmd_count),
        .cmd_interval (cmd_interval),
        .abort        (abort),
        .t_out        (t_out),
        .q            (q),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle index (after the handshake edge) in which done is expected
    function automatic int done_cycle(input vec_t v);
        if (v.abort_at >= 0) return v.abort_at + 1;
        if (v.count == 8'd0) return 0;
        return int'(v.count) + (int'(v.count) - 1) * int'(v.interval);
    endfunction

    // Issue one command and check every cycle until back in IDLE
    task automatic run_vec(input int idx, input vec_t v, inout logic [3:0] q_exp);
        int  d;
        int  step;
        bit  exp_t;
        d    = done_cycle(v);
        step = int'(v.interval) + 1;
        cmd_mask     = v.mask;
        cmd_count    = v.count;
        cmd_interval = v.interval;
        cmd_valid    = 1'b1;
        check($sformatf("v%0d ready_before", idx), 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int j = 0; j <= d + 1; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            abort = (j == v.abort_at);
            @(negedge clk);
            if (j <= d) begin
                exp_t = ((j % step) == 0) && ((j / step) < int'(v.count)) && (j != v.abort_at);
                check($sformatf("v%0d c%0d t_out", idx, j), 32'(t_out), exp_t ? 32'(v.mask) : 32'd0);
                check($sformatf("v%0d c%0d busy", idx, j), 32'(busy), 32'd1);
                check($sformatf("v%0d c%0d done", idx, j), 32'(done), (j == d) ? 32'd1 : 32'd0);
                check($sformatf("v%0d c%0d ready", idx, j), 32'(cmd_ready), 32'd0);
                check($sformatf("v%0d c%0d q", idx, j), 32'(q), 32'(q_exp));
                if (exp_t) q_exp = q_exp ^ v.mask;
            end else begin
                check($sformatf("v%0d idle ready", idx), 32'(cmd_ready), 32'd1);
                check($sformatf("v%0d idle busy", idx), 32'(busy), 32'd0);
                check($sformatf("v%0d idle done", idx), 32'(done), 32'd0);
                check($sformatf("v%0d q_end", idx), 32'(q), 32'(v.q_end));
            end
        end
        abort = 1'b0;
        q_exp = v.q_end;
    endtask

    initial begin
        logic [3:0] q_exp;
        bit         seen;

        vecs[0] = '{4'b1111, 8'd2,   8'd2,   -1, 4'b0000};
        vecs[1] = '{4'b0101, 8'd3,   8'd0,   -1, 4'b0101};
        vecs[2] = '{4'b1111, 8'd0,   8'd0,   -1, 4'b0101};
        vecs[3] = '{4'b0011, 8'd5,   8'd3,    1, 4'b0110};
        vecs[4] = '{4'b1000, 8'd1,   8'd5,   -1, 4'b1110};
        vecs[5] = '{4'b0001, 8'd4,   8'd1,   -1, 4'b1110};
        vecs[6] = '{4'b1111, 8'd3,   8'd1,    2, 4'b0001};
        vecs[7] = '{4'b0110, 8'd255, 8'd0,   -1, 4'b0111};
        vecs[8] = '{4'b1010, 8'd2,   8'd255, -1, 4'b0111};

        n_rst        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_mask     = '0;
        cmd_count    = '0;
        cmd_interval = '0;
        abort        = 1'b0;

        // Reset values while reset is held, then released off a clock edge
        #3;
        check("rst ready", 32'(cmd_ready), 32'd1);
        check("rst busy",  32'(busy),      32'd0);
        check("rst done",  32'(done),      32'd0);
        check("rst t_out", 32'(t_out),     32'd0);
        check("rst q",     32'(q),         32'd0);
        #4 n_rst = 1'b1;
        @(negedge clk);
        check("post_rst ready", 32'(cmd_ready), 32'd1);
        check("post_rst q",     32'(q),         32'd0);

        q_exp = 4'b0000;
        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i], q_exp);
        end

        // Command held while busy: second copy taken only after DONE
        cmd_mask     = 4'b0001;
        cmd_count    = 8'd2;
        cmd_interval = 8'd1;
        cmd_valid    = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 3; j++) begin
            @(negedge clk);
            check($sformatf("hold c%0d ready", j), 32'(cmd_ready), 32'd0);
            check($sformatf("hold c%0d done", j), 32'(done), (j == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("hold idle ready", 32'(cmd_ready), 32'd1);
        check("hold idle busy",  32'(busy),      32'd0);
        check("hold idle t_out", 32'(t_out),     32'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("hold second t_out", 32'(t_out), 32'b0001);
        check("hold second busy",  32'(busy),  32'd1);
        seen = 1'b0;
        for (int j = 0; j < 20 && !seen; j++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("hold second done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("hold q", 32'(q), 32'b0111);

        // Reset asserted in a PULSE cycle: immediate return, no done
        cmd_mask     = 4'b1111;
        cmd_count    = 8'd4;
        cmd_interval = 8'd0;
        cmd_valid    = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("mid t_out", 32'(t_out), 32'b1111);
        @(posedge clk);
        #1;
        check("mid q", 32'(q), 32'b1000);
        n_rst = 1'b0;
        #1;
        check("mid_rst q",     32'(q),         32'd0);
        check("mid_rst busy",  32'(busy),      32'd0);
        check("mid_rst ready", 32'(cmd_ready), 32'd1);
        check("mid_rst t_out", 32'(t_out),     32'd0);
        check("mid_rst done",  32'(done),      32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("mid_rst no_done", 32'(seen), 32'd0);
        check("mid_rst q_after", 32'(q),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
